tristate_bus_tx: RTL and testbench
==================================

// Module: tristate_bus_tx
// PURPOSE
//  Half-duplex serial transmitter that feeds the active-low tristate line buffer.
//  Drives its dataInput/outEnable pins so the shared wire carries one UART-style frame.
//  Frame: start, DATA_WIDTH bits LSB-first, stop.
//  Owns the wire only for the frame plus guard intervals. Releases it (outEnable=0) otherwise.
//  The buffer inverts, so this block pre-inverts: dataInput = ~lineLevel.
// PARAMETERS
//  DATA_WIDTH    8  payload bits per frame (>=1)
//  BIT_CYCLES    4  clocks per line bit (>=1)
//  GUARD_CYCLES  2  clocks line held idle-high after enable and before release (>=0)
// PORTS
//  clk         in   1           single clock, all state on rising edge
//  reset       in   1           synchronous, active-high
//  txData      in   DATA_WIDTH  payload, sampled on accept
//  txValid     in   1           producer has payload
//  txReady     out  1           block can accept payload (IDLE only)
//  busy        out  1           frame in progress (~txReady)
//  done        out  1           one-cycle pulse on return to IDLE after full frame
//  dataInput   out  1           to buffer data pin, inverted line level
//  outEnable   out  1           to buffer enable pin; 1 = drive wire, 0 = high-Z
// BEHAVIOUR
//  - Reset values: txReady=1, busy=0, done=0, outEnable=0, dataInput=0. FSM in IDLE. Counters cleared.
//  - All outputs registered. Reset mid-frame aborts at that edge: outEnable=0 next cycle, no done.
//  - Accept: txValid&&txReady at edge -> txData latched into shift reg. FSM leaves IDLE.
//    txReady=0 from the following cycle. txValid ignored while busy.
//  - FSM states, line level in brackets:
//    - IDLE (released)
//    - GUARD_ON (high), GUARD_CYCLES clocks
//    - START (low), BIT_CYCLES
//    - DATA (bit i), BIT_CYCLES per bit, DATA_WIDTH bits
//    - STOP (high), BIT_CYCLES
//    - GUARD_OFF (high), GUARD_CYCLES
//    - back to IDLE
//  - GUARD_CYCLES=0: GUARD_ON/GUARD_OFF skipped (IDLE->START, STOP->IDLE).
//  - outEnable=1 in every non-IDLE state, exactly 2*GUARD_CYCLES+(DATA_WIDTH+2)*BIT_CYCLES cycles.
//    Defaults: 44 cycles.
//  - First driven cycle is the cycle after the accept edge (latency 1).
//  - dataInput = ~level: high=0, low=1, data = ~shiftReg[0]. Shift right once per bit boundary.
//  - Bit timer counts 0..BIT_CYCLES-1. Terminal count advances bit or state. No drift across bits.
//  - Bit index counts 0..DATA_WIDTH-1. Terminal index with timer terminal -> STOP.
//  - done=1 for exactly the first IDLE cycle after a complete frame.
//    txReady=1 in that same cycle. Back-to-back accept there is legal.
//  - Back-to-back frames: released for >=1 cycle between frames (outEnable=0 in IDLE).
//  - Timer and index widths: $clog2 of max(BIT_CYCLES,GUARD_CYCLES,DATA_WIDTH)+1, min 1.
// STRUCTURE
//  - tristate_bus_pkg holds:
//    - state encoding localparams (IDLE, GUARD_ON, START, DATA, STOP, GUARD_OFF)
//    - LINE_IDLE=1'b1, LINE_START=1'b0
//    - clog2 helper function
//  - Sub-module bus_bit_timer (param COUNT): enable, clear, terminal pulse.
//    Reused for bit and guard timing.
//  - Top holds FSM, shift reg, bit index, output regs. Top instantiates no buffer; the buffer is a sibling.
// TESTING
//  1. Reset: hold reset 3 clks -> outEnable=0, txReady=1, done=0. Assert reset with txValid=1 -> no accept.
//  2. Send 8'hA5, defaults -> outEnable high 44 cycles starting 1 clk after accept.
//     Recovered line (~dataInput): 2 high, 4 low, bits 1,0,1,0,0,1,0,1 x4, 4 high, 2 high.
//     Then done pulse, outEnable=0.
//  3. txValid held high, 8'h00 then 8'hFF -> second accepted on done cycle.
//     Exactly 1 released cycle between frames. txData changes mid-frame ignored.
//  4. Reset asserted at cycle 20 of frame -> next cycle outEnable=0, IDLE, no done. New frame afterwards is clean.
//  5. GUARD_CYCLES=0, BIT_CYCLES=1, DATA_WIDTH=4, send 4'h6 -> 6 driven cycles, line 0,0,1,1,0,1.
//  6. Bench models buffer (~dataInput when enabled, else Z) and a pull-up. Checker decodes frame.
//     Wire never Z inside a frame, never driven in IDLE.

Source files
------------

// File: rtl/tristate_bus_pkg.sv
// tristate_bus_pkg: shared state encoding, line levels and sizing helper
// for the tristate bus transmitter.
package tristate_bus_pkg;
    typedef enum logic [2:0] {IDLE, GUARD_ON, START, DATA, STOP, GUARD_OFF} state_t;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic LINE_START = 1'b0;
    function automatic int clog2w(input int n);
        return n <= 2 ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/bus_bit_timer.sv
// bus_bit_timer: wrapping 0..COUNT-1 counter with a combinational terminal pulse,
// used for both line-bit and guard-interval timing.
module bus_bit_timer
    import tristate_bus_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int W = clog2w(COUNT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic terminal
);
    logic [W-1:0] cnt;
    assign terminal = enable && cnt == W'(COUNT - 1);
    always_ff @(posedge clk) begin
        if (reset || clear) cnt <= '0;
        else if (enable) cnt <= terminal ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/tristate_bus_tx.sv
// tristate_bus_tx: frames a payload onto an inverting tristate buffer, owning the
// wire only for guard + start + data + stop + guard, all outputs registered.
module tristate_bus_tx
    import tristate_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic                  txValid,
    output logic                  txReady,
    output logic                  busy,
    output logic                  done,
    output logic                  dataInput,
    output logic                  outEnable
);
    localparam int M1 = BIT_CYCLES > GUARD_CYCLES ? BIT_CYCLES : GUARD_CYCLES;
    localparam int MAXC = M1 > DATA_WIDTH ? M1 : DATA_WIDTH;
    localparam int W = clog2w(MAXC + 1);
    localparam int GC = GUARD_CYCLES > 0 ? GUARD_CYCLES : 1;
    localparam logic [W-1:0] LAST = W'(DATA_WIDTH - 1);
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [W-1:0] idx, idx_n;
    logic bit_term, guard_term, line_n;
    bus_bit_timer #(.COUNT(BIT_CYCLES), .W(W)) u_bit (
        .clk(clk), .reset(reset),
        .enable(state == START || state == DATA || state == STOP),
        .clear(state == IDLE), .terminal(bit_term)
    );
    // With GUARD_CYCLES=0 the guard states are never entered, so this timer idles.
    bus_bit_timer #(.COUNT(GC), .W(W)) u_guard (
        .clk(clk), .reset(reset),
        .enable(state == GUARD_ON || state == GUARD_OFF),
        .clear(state == IDLE), .terminal(guard_term)
    );
    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n = idx;
        unique case (state)
            IDLE: if (txValid) begin
                state_n = GUARD_CYCLES > 0 ? GUARD_ON : START;
                shift_n = txData;
            end
            GUARD_ON: if (guard_term) state_n = START;
            START: if (bit_term) state_n = DATA;
            DATA: if (bit_term) begin
                shift_n = shift >> 1;
                idx_n = idx == LAST ? '0 : idx + W'(1);
                state_n = idx == LAST ? STOP : DATA;
            end
            STOP: if (bit_term) state_n = GUARD_CYCLES > 0 ? GUARD_OFF : IDLE;
            GUARD_OFF: if (guard_term) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        line_n = state_n == DATA ? shift_n[0] : state_n == START ? LINE_START : LINE_IDLE;
    end
    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shift <= '0;
            idx <= '0;
            txReady <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            outEnable <= 1'b0;
            dataInput <= 1'b0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            idx <= idx_n;
            txReady <= state_n == IDLE;
            busy <= state_n != IDLE;
            done <= state != IDLE && state_n == IDLE;
            outEnable <= state_n != IDLE;
            dataInput <= ~line_n;
        end
    end
endmodule

// File: tb/tb_tristate_bus_tx.sv
// tb_tristate_bus_tx: directed checks of framing, timing, back-to-back, abort and a
// zero-guard configuration, decoding the pulled-up wire behind a modelled buffer.
module tb_tristate_bus_tx;
    logic clk = 1'b0, reset = 1'b1, valid = 1'b0, valid2 = 1'b0;
    logic [7:0] data = 8'h00;
    logic [3:0] data2 = 4'h0;
    logic ready, busy, done, di, oe, ready2, busy2, done2, di2, oe2;
    logic wire_line;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    tristate_bus_tx dut (
        .clk(clk), .reset(reset), .txData(data), .txValid(valid), .txReady(ready),
        .busy(busy), .done(done), .dataInput(di), .outEnable(oe)
    );
    tristate_bus_tx #(.DATA_WIDTH(4), .BIT_CYCLES(1), .GUARD_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .txData(data2), .txValid(valid2), .txReady(ready2),
        .busy(busy2), .done(done2), .dataInput(di2), .outEnable(oe2)
    );
    // Inverting buffer when enabled, pull-up when released.
    assign wire_line = oe ? ~di : 1'b1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    function automatic logic [63:0] line_of(input logic [7:0] d);
        logic [63:0] p;
        p = '1;
        for (int k = 2; k < 6; k++) p[k] = 1'b0;
        for (int b = 0; b < 8; b++)
            for (int j = 0; j < 4; j++) p[6 + 4 * b + j] = d[b];
        return p;
    endfunction
    function automatic logic [7:0] decode(input logic [63:0] p);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = p[8 + 4 * b];
        return r;
    endfunction
    task automatic capture(input bit second, output int n, output logic [63:0] pat);
        n = 0;
        pat = '1;
        while ((second ? oe2 : oe) && n < 64) begin
            pat[n] = second ? ~di2 : wire_line;
            n++;
            @(negedge clk);
        end
    endtask
    task automatic send(input logic [7:0] d);
        int n;
        logic [63:0] pat;
        chk("send_ready", ready, 1);
        valid = 1'b1;
        data = d;
        @(negedge clk);
        valid = 1'b0;
        data = ~d;
        chk("latency_oe", oe, 1);
        capture(0, n, pat);
        chk("frame_len", n, 44);
        chk("frame_line", pat, line_of(d));
        chk("frame_decode", decode(pat), d);
        chk("done_pulse", done, 1);
        chk("released_after", oe, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask
    always @(negedge clk)
        if (!reset && ready && oe) chk("idle_driven", oe, 0);
    typedef struct {
        logic rst;
        logic v;
        logic [7:0] d;
        logic [4:0] exp;
    } vec_t;
    vec_t vecs[9];
    initial begin
        int n;
        logic [63:0] pat;
        // exp = {txReady, busy, done, outEnable, dataInput}
        vecs[0] = '{1'b1, 1'b0, 8'h00, 5'b10000};
        vecs[1] = '{1'b1, 1'b0, 8'h00, 5'b10000};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 5'b10000};
        vecs[3] = '{1'b1, 1'b1, 8'hA5, 5'b10000};
        vecs[4] = '{1'b0, 1'b0, 8'hA5, 5'b10000};
        vecs[5] = '{1'b0, 1'b1, 8'hA5, 5'b01010};
        vecs[6] = '{1'b0, 1'b0, 8'hA5, 5'b01010};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 5'b10000};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 5'b10000};
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            reset = vecs[i].rst;
            valid = vecs[i].v;
            data = vecs[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {ready, busy, done, oe, di}, vecs[i].exp);
        end
        valid = 1'b0;
        send(8'hA5);
        send(8'h3C);
        // Held valid: second payload taken on the done cycle, mid-frame data change ignored.
        valid = 1'b1;
        data = 8'h00;
        @(negedge clk);
        data = 8'hFF;
        capture(0, n, pat);
        chk("b2b_len1", n, 44);
        chk("b2b_line1", pat, line_of(8'h00));
        chk("b2b_done1", done, 1);
        chk("b2b_ready1", ready, 1);
        @(negedge clk);
        valid = 1'b0;
        chk("b2b_gap", oe, 1);
        capture(0, n, pat);
        chk("b2b_len2", n, 44);
        chk("b2b_line2", pat, line_of(8'hFF));
        chk("b2b_done2", done, 1);
        @(negedge clk);
        // Reset at frame cycle 20 aborts without done.
        valid = 1'b1;
        data = 8'h5A;
        @(negedge clk);
        valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_pre_oe", oe, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_oe", oe, 0);
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        @(negedge clk);
        chk("abort_no_late_done", done, 0);
        send(8'hC3);
        // Zero-guard, one clock per bit, 4-bit payload.
        valid2 = 1'b1;
        data2 = 4'h6;
        @(negedge clk);
        valid2 = 1'b0;
        capture(1, n, pat);
        chk("small_len", n, 6);
        chk("small_line", pat[5:0], 6'b101100);
        chk("small_done", done2, 1);
        chk("small_released", oe2, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
